// File: rtl/fetch_queue_mi.sv
// Multi-issue fetch queue: FETCH_W-wide push and ISSUE_W-wide peek/pop over a DEPTH-entry ring.
// Define FQ_STATS_EN to add the fq_o_stall_cnt and fq_o_max_level statistics outputs.
module fetch_queue_mi #(
    parameter int unsigned IWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned FETCH_W  = 2,
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                           fq_clk,
    input  logic                           fq_rst,
    input  logic                           fq_i_flush,
    input  logic                           fq_i_valid,
    input  logic [$clog2(FETCH_W+1)-1:0]   fq_i_count,
    input  logic [FETCH_W*IWIDTH-1:0]      fq_i_instr,
    input  logic [FETCH_W*PC_WIDTH-1:0]    fq_i_pc,
    output logic                           fq_o_ready,
    output logic [$clog2(ISSUE_W+1)-1:0]   fq_o_count,
    output logic [ISSUE_W*IWIDTH-1:0]      fq_o_instr,
    output logic [ISSUE_W*PC_WIDTH-1:0]    fq_o_pc,
    input  logic [$clog2(ISSUE_W+1)-1:0]   fq_i_take,
`ifdef FQ_STATS_EN
    output logic [31:0]                    fq_o_stall_cnt,
    output logic [$clog2(DEPTH+1)-1:0]     fq_o_max_level,
`endif
    output logic [$clog2(DEPTH+1)-1:0]     fq_o_level
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned FCW = $clog2(FETCH_W + 1);
    localparam int unsigned ICW = $clog2(ISSUE_W + 1);
    localparam int unsigned LW  = $clog2(DEPTH + 1);

    logic [IWIDTH-1:0]   mem_instr [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc    [DEPTH];

    logic [PW-1:0]  head_q, tail_q;
    logic [LW-1:0]  level_q, level_d;
    logic [FCW-1:0] push_n;
    logic [ICW-1:0] out_cnt, taken;

    // Readiness deliberately ignores a same-cycle pop.
    assign fq_o_ready = ((LW+1)'(level_q) + (LW+1)'(FETCH_W)) <= (LW+1)'(DEPTH);

    always_comb begin
        push_n = '0;
        if (fq_i_valid && fq_o_ready && !fq_i_flush && !fq_rst) begin
            push_n = (fq_i_count > FCW'(FETCH_W)) ? FCW'(FETCH_W) : fq_i_count;
        end
    end

    always_comb begin
        if (level_q >= LW'(ISSUE_W)) out_cnt = ICW'(ISSUE_W);
        else                         out_cnt = ICW'(level_q);
    end

    assign taken   = (fq_i_take > out_cnt) ? out_cnt : fq_i_take;
    assign level_d = level_q + LW'(push_n) - LW'(taken);

    always_ff @(posedge fq_clk) begin
        if (fq_rst || fq_i_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_q + PW'(taken);
            tail_q  <= tail_q + PW'(push_n);
            level_q <= level_d;
        end
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge fq_clk) begin
        for (int unsigned k = 0; k < FETCH_W; k++) begin
            if (FCW'(k) < push_n) begin
                mem_instr[tail_q + PW'(k)] <= fq_i_instr[k*IWIDTH +: IWIDTH];
                mem_pc[tail_q + PW'(k)]    <= fq_i_pc[k*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    always_comb begin
        fq_o_instr = '0;
        fq_o_pc    = '0;
        for (int unsigned j = 0; j < ISSUE_W; j++) begin
            if (ICW'(j) < out_cnt) begin
                fq_o_instr[j*IWIDTH +: IWIDTH]   = mem_instr[head_q + PW'(j)];
                fq_o_pc[j*PC_WIDTH +: PC_WIDTH]  = mem_pc[head_q + PW'(j)];
            end
        end
    end

    assign fq_o_count = out_cnt;
    assign fq_o_level = level_q;

`ifdef FQ_STATS_EN
    logic [31:0]   stall_q;
    logic [LW-1:0] max_q;

    always_ff @(posedge fq_clk) begin
        if (fq_rst) begin
            stall_q <= '0;
            max_q   <= '0;
        end else begin
            if (fq_i_valid && !fq_o_ready && !fq_i_flush && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (level_d > max_q) max_q <= level_d;
        end
    end

    assign fq_o_stall_cnt = stall_q;
    assign fq_o_max_level = max_q;
`endif

endmodule

// File: tb/tb_fetch_queue_mi.sv
// Directed plus randomized bench for fetch_queue_mi against a queue-based reference model.
module tb_fetch_queue_mi;
    localparam int IW = 32, PW = 32, FW = 2, IS = 2, D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush, valid;
    logic [1:0]      cnt, take;
    logic [FW*IW-1:0] instr;
    logic [FW*PW-1:0] pc;
    logic            ready;
    logic [1:0]      ocount;
    logic [IS*IW-1:0] oinstr;
    logic [IS*PW-1:0] opc;
    logic [3:0]      level;
`ifdef FQ_STATS_EN
    logic [31:0]     stall_cnt;
    logic [3:0]      max_level;
`endif

    fetch_queue_mi dut (
        .fq_clk     (clk),
        .fq_rst     (rst),
        .fq_i_flush (flush),
        .fq_i_valid (valid),
        .fq_i_count (cnt),
        .fq_i_instr (instr),
        .fq_i_pc    (pc),
        .fq_o_ready (ready),
        .fq_o_count (ocount),
        .fq_o_instr (oinstr),
        .fq_o_pc    (opc),
        .fq_i_take  (take),
`ifdef FQ_STATS_EN
        .fq_o_stall_cnt (stall_cnt),
        .fq_o_max_level (max_level),
`endif
        .fq_o_level (level)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned pc_seq = 0;
    int          m_stall = 0;
    int          m_max = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int          c;
        logic [31:0] ei, ep;
        c = (q.size() < IS) ? q.size() : IS;
        chk("level", 64'(level), 64'(q.size()));
        chk("out_count", 64'(ocount), 64'(c));
        chk("ready", 64'(ready), 64'((D - q.size()) >= FW));
        for (int j = 0; j < IS; j++) begin
            ei = 32'd0;
            ep = 32'd0;
            if (j < c) begin
                ei = q[j].ins;
                ep = q[j].pc;
            end
            chk($sformatf("lane%0d_instr", j), 64'(oinstr[j*IW +: IW]), 64'(ei));
            chk($sformatf("lane%0d_pc", j), 64'(opc[j*PW +: PW]), 64'(ep));
        end
`ifdef FQ_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("max_level", 64'(max_level), 64'(m_max));
`endif
    endtask

    // Fresh random instructions with PCs continuing the accepted stream.
    task automatic gen();
        for (int k = 0; k < FW; k++) begin
            instr[k*IW +: IW] = $urandom;
            pc[k*PW +: PW]    = pc_seq + 32'(4 * k);
        end
    endtask

    // Check current state, then advance the model and DUT by one clock.
    task automatic step(input bit r, input bit f, input bit v, input int c, input int t);
        int pushed, taken, avail;
        bit rdy;
        rst   = r;
        flush = f;
        valid = v;
        cnt   = 2'(c);
        take  = 2'(t);
        check_state();
        rdy = (D - q.size()) >= FW;
        if (r) begin
            q.delete();
            m_stall = 0;
            m_max   = 0;
        end else begin
            if (v && !rdy && !f) m_stall++;
            if (f) begin
                q.delete();
            end else begin
                avail = (q.size() < IS) ? q.size() : IS;
                taken = (t < avail) ? t : avail;
                repeat (taken) void'(q.pop_front());
                if (v && rdy) begin
                    pushed = (c > FW) ? FW : c;
                    for (int k = 0; k < pushed; k++) begin
                        q.push_back({instr[k*IW +: IW], pc[k*PW +: PW]});
                    end
                    pc_seq += 32'(4 * pushed);
                end
            end
            if (q.size() > m_max) m_max = q.size();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        valid = 1'b1;
        cnt   = 2'd2;
        take  = 2'd0;
        instr = '0;
        pc    = '0;
        @(posedge clk);
        #1;
        step(1, 0, 1, 2, 0);

        instr = {32'hA1, 32'hA0};
        pc    = {32'd4, 32'd0};
        step(0, 0, 1, 2, 0);
        chk("first_lane0_instr", 64'(oinstr[31:0]), 64'h0A0);
        chk("first_lane1_pc", 64'(opc[63:32]), 64'd4);

        repeat (3) begin
            gen();
            step(0, 0, 1, 2, 0);
        end
        chk("full_level", 64'(level), 64'd8);
        chk("full_ready", 64'(ready), 64'd0);
        gen();
        step(0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 2);

        repeat (8) begin
            gen();
            step(0, 0, 1, 2, 2);
            chk("steady_level", 64'(level), 64'd6);
        end

        step(0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 2);
        chk("overtake_level", 64'(level), 64'd0);
        chk("overtake_count", 64'(ocount), 64'd0);

        gen(); step(0, 0, 1, 2, 0);
        gen(); step(0, 0, 1, 2, 0);
        gen(); step(0, 0, 1, 1, 0);
        gen(); step(0, 1, 1, 2, 2);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_ready", 64'(ready), 64'd1);
        step(0, 0, 0, 0, 0);

        repeat (400) begin
            gen();
            step($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end
        step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
